// File: rtl/census_window_ctrl.sv
// rtl/census_window_ctrl.sv - census window scan controller; CENSUS_CTRL_BORDER_EN adds edge windows and a DRAIN flush
module census_window_ctrl #(
    parameter int IMG_W   = 320,
    parameter int IMG_H   = 240,
    parameter int WIN     = 7,
    parameter int COORD_W = 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               in_valid,
    output logic               in_ready,
    output logic               shift_en,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [COORD_W-1:0] out_col,
    output logic [COORD_W-1:0] out_row,
    output logic               border,
    output logic               busy,
    output logic               frame_done
);

    localparam int HALF = (WIN - 1) / 2;
    localparam logic [COORD_W-1:0] C_LAST_COL = COORD_W'(IMG_W - 1);
    localparam logic [COORD_W-1:0] C_LAST_ROW = COORD_W'(IMG_H - 1);
    localparam logic [COORD_W-1:0] C_HALF     = COORD_W'(HALF);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    state_t             r_state;
    logic [COORD_W-1:0] r_col;
    logic [COORD_W-1:0] r_row;
    logic               r_out_valid;
    logic [COORD_W-1:0] r_out_col;
    logic [COORD_W-1:0] r_out_row;
    logic               r_border;
    logic               r_frame_done;

    logic               w_out_free;
    logic               w_in_ready;
    logic               w_accept;
    logic               w_last_px;
    logic               w_emit;
    logic               w_drain_done;
    logic [COORD_W-1:0] w_em_col;
    logic [COORD_W-1:0] w_em_row;
    logic               w_em_border;

    assign w_out_free = !r_out_valid || out_ready;
    assign w_in_ready = (r_state == S_ACTIVE) && w_out_free;
    assign w_accept   = in_valid && w_in_ready;
    assign w_last_px  = (r_col == C_LAST_COL) && (r_row == C_LAST_ROW);

`ifdef CENSUS_CTRL_BORDER_EN
    // Window centres trail the accepted pixel by HALF rows plus HALF columns in raster order;
    // the last HALF*IMG_W+HALF centres have no later pixel and are flushed during DRAIN.
    localparam int FLUSH_N = HALF * IMG_W + HALF;
    localparam logic [2*COORD_W-1:0] C_FLUSH_N = (2*COORD_W)'(FLUSH_N);
    localparam logic [COORD_W-1:0]   C_BR_COL  = COORD_W'(IMG_W - 1 - HALF);
    localparam logic [COORD_W-1:0]   C_BR_ROW  = COORD_W'(IMG_H - 1 - HALF);

    logic [COORD_W-1:0]   r_ocol;
    logic [COORD_W-1:0]   r_orow;
    logic [2*COORD_W-1:0] r_flush;
    logic                 w_started;

    assign w_started    = (r_row > C_HALF) || ((r_row == C_HALF) && (r_col >= C_HALF));
    assign w_emit       = (w_accept && w_started) ||
                          ((r_state == S_DRAIN) && (r_flush != '0) && w_out_free);
    assign w_drain_done = w_out_free && (r_flush == '0);
    assign w_em_col     = r_ocol;
    assign w_em_row     = r_orow;
    assign w_em_border  = (r_ocol < C_HALF) || (r_ocol > C_BR_COL) ||
                          (r_orow < C_HALF) || (r_orow > C_BR_ROW);
`else
    localparam logic [COORD_W-1:0] C_WIN_M1 = COORD_W'(WIN - 1);

    assign w_emit       = w_accept && (r_col >= C_WIN_M1) && (r_row >= C_WIN_M1);
    assign w_drain_done = w_out_free;
    assign w_em_col     = r_col - C_HALF;
    assign w_em_row     = r_row - C_HALF;
    assign w_em_border  = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_col        <= '0;
            r_row        <= '0;
            r_out_valid  <= 1'b0;
            r_out_col    <= '0;
            r_out_row    <= '0;
            r_border     <= 1'b0;
            r_frame_done <= 1'b0;
`ifdef CENSUS_CTRL_BORDER_EN
            r_ocol       <= '0;
            r_orow       <= '0;
            r_flush      <= '0;
`endif
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_state <= S_ACTIVE;
                        r_col   <= '0;
                        r_row   <= '0;
`ifdef CENSUS_CTRL_BORDER_EN
                        r_ocol  <= '0;
                        r_orow  <= '0;
                        r_flush <= C_FLUSH_N;
`endif
                    end
                end
                S_ACTIVE: begin
                    if (w_accept) begin
                        if (w_last_px) begin
                            r_state <= S_DRAIN;
                            r_col   <= '0;
                            r_row   <= '0;
                        end else if (r_col == C_LAST_COL) begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end else begin
                            r_col <= r_col + 1'b1;
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_drain_done) begin
                        r_state      <= S_IDLE;
                        r_frame_done <= 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase

            if (w_emit) begin
                r_out_valid <= 1'b1;
                r_out_col   <= w_em_col;
                r_out_row   <= w_em_row;
                r_border    <= w_em_border;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end

`ifdef CENSUS_CTRL_BORDER_EN
            if (w_emit) begin
                if (r_ocol == C_LAST_COL) begin
                    r_ocol <= '0;
                    r_orow <= r_orow + 1'b1;
                end else begin
                    r_ocol <= r_ocol + 1'b1;
                end
                if (r_state == S_DRAIN) begin
                    r_flush <= r_flush - 1'b1;
                end
            end
`endif
        end
    end

    assign in_ready   = w_in_ready;
    assign shift_en   = w_accept;
    assign out_valid  = r_out_valid;
    assign out_col    = r_out_col;
    assign out_row    = r_out_row;
    assign border     = r_border;
    assign busy       = (r_state != S_IDLE);
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_census_window_ctrl.sv
// tb/tb_census_window_ctrl.sv - directed frame-table bench for census_window_ctrl (8x6 image, 3x3 window)
module tb_census_window_ctrl;

    localparam int IMG_W = 8;
    localparam int IMG_H = 6;
    localparam int WIN   = 3;
    localparam int CW    = 10;

`ifdef CENSUS_CTRL_BORDER_EN
    localparam int EXP_BEATS = 48;
    localparam int EXP_B1    = 24;
    localparam int FIRST_C   = 0;
    localparam int FIRST_R   = 0;
    localparam int LAST_C    = 7;
    localparam int LAST_R    = 5;
    localparam int TRIG_IDX  = 9;
`else
    localparam int EXP_BEATS = 24;
    localparam int EXP_B1    = 0;
    localparam int FIRST_C   = 1;
    localparam int FIRST_R   = 1;
    localparam int LAST_C    = 6;
    localparam int LAST_R    = 4;
    localparam int TRIG_IDX  = 18;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic          out_ready = 1'b1;
    logic          in_ready, shift_en, out_valid, border, busy, frame_done;
    logic [CW-1:0] out_col, out_row;

    int n_checks = 0;
    int n_fail   = 0;

    census_window_ctrl #(.IMG_W(IMG_W), .IMG_H(IMG_H), .WIN(WIN), .COORD_W(CW)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .shift_en(shift_en), .out_valid(out_valid), .out_ready(out_ready),
        .out_col(out_col), .out_row(out_row), .border(border), .busy(busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rnd;
        bit start_mid;
        int stall_at;
        int stall_len;
        int exp_beats;
        int exp_shifts;
        int exp_b1;
    } vec_t;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic run_frame(input vec_t v, input int idx);
        int ec[$];
        int er[$];
        int eb[$];
        int cyc, beats, shifts, fd_cnt, fd_cyc, lb_cyc, fv_cyc, trig_cyc, stall_left, nb1, mism;
        int fc, fr, lc, lr;
        bit stalled;
        logic [CW-1:0] hc, hr;
`ifdef CENSUS_CTRL_BORDER_EN
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++) begin
                ec.push_back(c); er.push_back(r);
                eb.push_back((c == 0 || c == IMG_W-1 || r == 0 || r == IMG_H-1) ? 1 : 0);
            end
`else
        for (int r = 1; r <= IMG_H-2; r++)
            for (int c = 1; c <= IMG_W-2; c++) begin
                ec.push_back(c); er.push_back(r); eb.push_back(0);
            end
`endif
        beats = 0; shifts = 0; fd_cnt = 0; fd_cyc = -1; lb_cyc = -1; fv_cyc = -1;
        trig_cyc = -1; stall_left = 0; nb1 = 0; mism = 0; stalled = 0;
        fc = -1; fr = -1; lc = -1; lr = -1; hc = '0; hr = '0;

        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        cyc = 0;
        while (fd_cnt == 0 && cyc < 2000) begin
            @(posedge clk); #1;
            start = (v.start_mid && cyc == 20);
            in_valid = v.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (!stalled && v.stall_len > 0 && out_valid && beats == v.stall_at) begin
                stalled = 1; stall_left = v.stall_len; hc = out_col; hr = out_row;
            end
            if (stall_left > 0) begin
                out_ready = 1'b0; stall_left--;
            end else begin
                out_ready = 1'b1;
            end
            @(negedge clk);
            check($sformatf("f%0d shift_en rule", idx), shift_en, in_valid & in_ready);
            if (!out_ready) begin
                check($sformatf("f%0d stall in_ready", idx), in_ready, 0);
                check($sformatf("f%0d stall shift_en", idx), shift_en, 0);
                check($sformatf("f%0d stall out_valid", idx), out_valid, 1);
                check($sformatf("f%0d stall out_col", idx), out_col, hc);
                check($sformatf("f%0d stall out_row", idx), out_row, hr);
            end
            if (shift_en) begin
                if (shifts == TRIG_IDX) trig_cyc = cyc;
                shifts++;
            end
            if (out_valid && fv_cyc < 0) fv_cyc = cyc;
            if (out_valid && out_ready) begin
                if (beats < ec.size()) begin
                    if (out_col != ec[beats] || out_row != er[beats] || border != eb[beats]) mism++;
                end else begin
                    mism++;
                end
                if (border) nb1++;
                if (beats == 0) begin fc = out_col; fr = out_row; end
                lc = out_col; lr = out_row; lb_cyc = cyc;
                beats++;
            end
            if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
            cyc++;
        end
        if (fd_cnt == 0) check($sformatf("f%0d frame_done timeout", idx), 0, 1);
        check($sformatf("f%0d beats", idx), beats, v.exp_beats);
        check($sformatf("f%0d shifts", idx), shifts, v.exp_shifts);
        check($sformatf("f%0d sequence mismatches", idx), mism, 0);
        check($sformatf("f%0d border=1 beats", idx), nb1, v.exp_b1);
        check($sformatf("f%0d first col", idx), fc, FIRST_C);
        check($sformatf("f%0d first row", idx), fr, FIRST_R);
        check($sformatf("f%0d last col", idx), lc, LAST_C);
        check($sformatf("f%0d last row", idx), lr, LAST_R);
        check($sformatf("f%0d first window latency", idx), fv_cyc, trig_cyc + 1);
        check($sformatf("f%0d frame_done after last beat", idx), fd_cyc, lb_cyc + 1);
        in_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("f%0d frame_done single pulse", idx), frame_done, 0);
            check($sformatf("f%0d busy after frame", idx), busy, 0);
        end
    endtask

    vec_t tbl[5];

    initial begin
        int cyc;
        bit fd_seen;
        tbl[0] = '{rnd: 0, start_mid: 0, stall_at: 0, stall_len: 0,
                   exp_beats: EXP_BEATS, exp_shifts: 48, exp_b1: EXP_B1};
        tbl[1] = '{rnd: 0, start_mid: 0, stall_at: 5, stall_len: 5,
                   exp_beats: EXP_BEATS, exp_shifts: 48, exp_b1: EXP_B1};
        tbl[2] = '{rnd: 1, start_mid: 0, stall_at: 0, stall_len: 0,
                   exp_beats: EXP_BEATS, exp_shifts: 48, exp_b1: EXP_B1};
        tbl[3] = '{rnd: 1, start_mid: 1, stall_at: 3, stall_len: 5,
                   exp_beats: EXP_BEATS, exp_shifts: 48, exp_b1: EXP_B1};
        tbl[4] = '{rnd: 0, start_mid: 1, stall_at: 0, stall_len: 0,
                   exp_beats: EXP_BEATS, exp_shifts: 48, exp_b1: EXP_B1};

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset busy", busy, 0);
        check("reset out_valid", out_valid, 0);
        check("reset out_col", out_col, 0);
        check("reset out_row", out_row, 0);
        check("reset border", border, 0);
        check("reset frame_done", frame_done, 0);
        check("reset in_ready", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // in_valid while idle must not be accepted
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("idle in_ready", in_ready, 0);
            check("idle shift_en", shift_en, 0);
            check("idle busy", busy, 0);
        end
        in_valid = 1'b0;

        for (int i = 0; i < 5; i++) run_frame(tbl[i], i);

        // abort a frame with reset while pixel (5,3) is being accepted
        @(posedge clk); #1;
        start = 1'b1; out_ready = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; in_valid = 1'b1;
        cyc = 0;
        fd_seen = 0;
        while (cyc < 200) begin
            @(negedge clk);
            if (frame_done) fd_seen = 1;
            if (shift_en && dut.r_col == 5 && dut.r_row == 3) break;
            cyc++;
        end
        check("abort reached pixel (5,3)", (cyc < 200) ? 1 : 0, 1);
        #1 rst = 1'b0;
        #1;
        check("async rst busy", busy, 0);
        check("async rst out_valid", out_valid, 0);
        check("async rst in_ready", in_ready, 0);
        check("async rst shift_en", shift_en, 0);
        check("async rst out_col", out_col, 0);
        check("async rst out_row", out_row, 0);
        @(posedge clk); #1;
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (frame_done) fd_seen = 1;
            check("post-abort idle busy", busy, 0);
            check("post-abort in_ready", in_ready, 0);
        end
        check("aborted frame frame_done", fd_seen ? 1 : 0, 0);
        in_valid = 1'b0;

        run_frame(tbl[0], 5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/census_window_ctrl.md
CENSUS_WINDOW_CTRL -- requirements
Module: census_window_ctrl

Interface
REQ-001: The module SHALL have parameter IMG_W, default 320, image width in pixels.
REQ-002: The module SHALL have parameter IMG_H, default 240, image height in rows.
REQ-003: The module SHALL have parameter WIN, default 7, census window edge (odd, 3..15, WIN<=IMG_W, WIN<=IMG_H).
REQ-004: The module SHALL have parameter COORD_W, default 10, coordinate counter width.
REQ-005: The module SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-006: The module SHALL have port rst  input  1  asynchronous active-low reset.
REQ-007: The module SHALL have port start  input  1  begin frame, sampled only in IDLE.
REQ-008: The module SHALL have port in_valid  input  1  upstream pixel present.
REQ-009: The module SHALL have port in_ready  output  1  pixel accepted when in_valid&in_ready.
REQ-010: The module SHALL have port shift_en  output  1  enable to line-buffer/tapped shift chain.
REQ-011: The module SHALL have port out_valid  output  1  window at taps complete.
REQ-012: The module SHALL have port out_ready  input  1  downstream census stage accepts.
REQ-013: The module SHALL have port out_col  output  COORD_W  centre column of emitted window.
REQ-014: The module SHALL have port out_row  output  COORD_W  centre row of emitted window.
REQ-015: The module SHALL have port border  output  1  emitted window overlaps image edge.
REQ-016: The module SHALL have port busy  output  1  state != IDLE.
REQ-017: The module SHALL have port frame_done  output  1  one-cycle end-of-frame pulse.

Function
REQ-018: FSM SHALL have states IDLE, ACTIVE, DRAIN; IDLE->ACTIVE on start; ACTIVE->DRAIN on accepting pixel (IMG_W-1, IMG_H-1); DRAIN->IDLE when out_valid==0 or out_valid&out_ready.
REQ-019: in_ready SHALL be combinational: (state==ACTIVE) && (!out_valid || out_ready).
REQ-020: shift_en SHALL equal in_valid&in_ready in the same cycle (no shift on stall).
REQ-021: Counters col/row SHALL mark the accepted pixel; col wraps IMG_W-1->0 with row+1; row clears to 0 on IDLE->ACTIVE.
REQ-022: Window complete SHALL mean accepted pixel has col>=WIN-1 and row>=WIN-1.
REQ-023: On accepted complete pixel, out_valid SHALL be 1 the next cycle, out_col=col-(WIN-1)/2, out_row=row-(WIN-1)/2 (latency 1, aligned to taps update).
REQ-024: Otherwise out_valid SHALL clear when out_ready=1 and hold (with out_col/out_row/border stable) while out_ready=0.
REQ-025: frame_done SHALL pulse for exactly one cycle on the DRAIN->IDLE transition.
REQ-026: start while busy SHALL be ignored; in_valid in IDLE/DRAIN SHALL not be accepted.
REQ-027: Per frame, exactly (IMG_W-WIN+1)*(IMG_H-WIN+1) windows SHALL be emitted with border=0 (interior only, macro absent).

Reset
REQ-028: Asserting rst (low) SHALL, asynchronously, force IDLE, col=row=0, out_valid=0, out_col=out_row=0, border=0, frame_done=0, busy=0; in_ready and shift_en then read 0.
REQ-029: Reset mid-frame SHALL discard the frame; no frame_done is produced for it.

Configuration
REQ-030: With CENSUS_CTRL_BORDER_EN defined, every accepted pixel with row>=(WIN-1)/2 and col>=(WIN-1)/2, plus a flush of the trailing (WIN-1)/2 rows/columns in DRAIN, SHALL emit a window, IMG_W*IMG_H total per frame, border=1 where the window overlaps an image edge.
REQ-031: Without CENSUS_CTRL_BORDER_EN, border SHALL be tied 0 and only REQ-027 interior windows emitted.

Verification
REQ-032: IMG_W=8, IMG_H=6, WIN=3, start, in_valid=1, out_ready=1 continuous -> 48 shift_en cycles, 24 out_valid beats, first (out_col,out_row)=(1,1) one cycle after pixel (2,2) accepted, last (6,4), frame_done one cycle after final beat.
REQ-033: Same config, out_ready=0 for 5 cycles during out_valid -> in_ready=0, shift_en=0, out_col/out_row held, no pixel lost; total still 24 beats.
REQ-034: in_valid toggled 1/0 randomly -> counters advance only on handshake; emitted coordinate sequence identical to REQ-032.
REQ-035: rst low at pixel (5,3) -> next cycle IDLE, out_valid=0; new start gives full 24-beat frame with first window (1,1).
REQ-036: start pulsed during ACTIVE and in_valid in IDLE -> no effect, in_ready=0 in IDLE.
REQ-037: CENSUS_CTRL_BORDER_EN defined, same config -> 48 beats, 24 with border=0, 24 with border=1, first (0,0) border=1.
